// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master between fetch, load/store and
// peripheral requesters, with per-device chip selects and a WAIT watchdog.
module spi_bus_arbiter #(
  parameter int ADDR_W  = 17,
  parameter int TIMEOUT = 255,
  parameter int CS_GAP  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_is_write,
  input  logic [2:0]        ls_num_bytes,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  input  logic              pe_req,
  input  logic [7:0]        pe_tx_byte,
  output logic              pe_done,
  output logic [31:0]       rdata,
  output logic              resp_err,
  output logic [1:0]        grant_id,
  output logic              spi_start,
  input  logic              spi_done,
  output logic [2:0]        spi_num_bytes,
  output logic              spi_is_peripheral,
  output logic [7:0]        spi_tx_byte,
  output logic [15:0]       spi_addr,
  output logic              spi_is_write,
  output logic [31:0]       spi_wdata,
  input  logic [31:0]       spi_rdata,
  output logic              flash_cs_n,
  output logic              ram_cs_n,
  output logic              periph_cs_n
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_RESP} state_e;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_IF   = 2'd1;
  localparam logic [1:0] G_LS   = 2'd2;
  localparam logic [1:0] G_PE   = 2'd3;

  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id == G_PE) ? G_IF : id + 2'd1;
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  rr_q, rr_d;
  logic [2:0]  gap_q, gap_d;
  logic [7:0]  wdog_q, wdog_d;
  logic [1:0]  grant_id_q, grant_id_d;
  logic        flash_cs_n_q, flash_cs_n_d;
  logic        ram_cs_n_q, ram_cs_n_d;
  logic        periph_cs_n_q, periph_cs_n_d;
  logic        spi_start_q, spi_start_d;
  logic        if_done_q, if_done_d;
  logic        ls_done_q, ls_done_d;
  logic        pe_done_q, pe_done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [2:0]  num_bytes_q, num_bytes_d;
  logic        is_periph_q, is_periph_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [15:0] addr_q, addr_d;
  logic        is_write_q, is_write_d;
  logic [31:0] wdata_q, wdata_d;

  logic [3:0] req_vec;
  logic [1:0] c0, c1, c2, win_id;
  logic       cur_req;
  logic       finish, timed_out;

  // Index 0 is "no grant", so a requester id indexes its own req bit directly.
  assign req_vec = {pe_req, ls_req, if_req, 1'b0};
  assign cur_req = req_vec[grant_id_q];

  always_comb begin
    c0 = rr_q;
    c1 = next_id(c0);
    c2 = next_id(c1);
    if (req_vec[c0])      win_id = c0;
    else if (req_vec[c1]) win_id = c1;
    else if (req_vec[c2]) win_id = c2;
    else                  win_id = G_NONE;
  end

  always_comb begin
    // NOTE: every *_d starts as its *_q so unassigned paths hold state
    // instead of inferring latches.
    state_d       = state_q;
    rr_d          = rr_q;
    gap_d         = gap_q;
    wdog_d        = wdog_q;
    grant_id_d    = grant_id_q;
    flash_cs_n_d  = flash_cs_n_q;
    ram_cs_n_d    = ram_cs_n_q;
    periph_cs_n_d = periph_cs_n_q;
    spi_start_d   = spi_start_q;
    if_done_d     = if_done_q;
    ls_done_d     = ls_done_q;
    pe_done_d     = pe_done_q;
    rdata_d       = rdata_q;
    resp_err_d    = resp_err_q;
    num_bytes_d   = num_bytes_q;
    is_periph_d   = is_periph_q;
    tx_byte_d     = tx_byte_q;
    addr_d        = addr_q;
    is_write_d    = is_write_q;
    wdata_d       = wdata_q;
    timed_out     = (wdog_q == 8'(TIMEOUT));
    finish        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (gap_q != 3'd0) begin
          gap_d = gap_q - 3'd1;
        end else if (win_id != G_NONE) begin
          grant_id_d = win_id;
          rr_d       = next_id(win_id);
          state_d    = S_SETUP;
          tx_byte_d  = 8'h00;
          wdata_d    = 32'h0;
          unique case (win_id)
            G_IF: begin
              addr_d       = if_addr[15:0];
              num_bytes_d  = 3'd4;
              is_write_d   = 1'b0;
              is_periph_d  = 1'b0;
              ram_cs_n_d   = ~if_addr[ADDR_W-1];
              flash_cs_n_d = if_addr[ADDR_W-1];
            end
            G_LS: begin
              addr_d       = ls_addr[15:0];
              num_bytes_d  = (ls_num_bytes == 3'd1 || ls_num_bytes == 3'd2) ? ls_num_bytes : 3'd4;
              is_write_d   = ls_is_write;
              wdata_d      = ls_wdata;
              is_periph_d  = 1'b0;
              ram_cs_n_d   = ~ls_addr[ADDR_W-1];
              flash_cs_n_d = ls_addr[ADDR_W-1];
            end
            default: begin
              addr_d        = 16'h0;
              num_bytes_d   = 3'd1;
              is_write_d    = 1'b0;
              is_periph_d   = 1'b1;
              tx_byte_d     = pe_tx_byte;
              periph_cs_n_d = 1'b0;
            end
          endcase
        end
      end
      S_SETUP: begin
        spi_start_d = 1'b1;
        wdog_d      = 8'd0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (spi_done) begin
          finish     = 1'b1;
          rdata_d    = spi_rdata;
          resp_err_d = 1'b0;
        end else if (timed_out) begin
          finish     = 1'b1;
          resp_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      default: begin
        // A requester that already dropped req never sees done.
        if (!cur_req) begin
          if_done_d  = 1'b0;
          ls_done_d  = 1'b0;
          pe_done_d  = 1'b0;
          grant_id_d = G_NONE;
          gap_d      = 3'(CS_GAP - 1);
          state_d    = S_IDLE;
        end
      end
    endcase

    if (finish) begin
      spi_start_d   = 1'b0;
      flash_cs_n_d  = 1'b1;
      ram_cs_n_d    = 1'b1;
      periph_cs_n_d = 1'b1;
      if_done_d     = (grant_id_q == G_IF) && if_req;
      ls_done_d     = (grant_id_q == G_LS) && ls_req;
      pe_done_d     = (grant_id_q == G_PE) && pe_req;
      state_d       = S_RESP;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_q          <= G_IF;
      gap_q         <= 3'd0;
      wdog_q        <= 8'd0;
      grant_id_q    <= G_NONE;
      flash_cs_n_q  <= 1'b1;
      ram_cs_n_q    <= 1'b1;
      periph_cs_n_q <= 1'b1;
      spi_start_q   <= 1'b0;
      if_done_q     <= 1'b0;
      ls_done_q     <= 1'b0;
      pe_done_q     <= 1'b0;
      rdata_q       <= 32'h0;
      resp_err_q    <= 1'b0;
      num_bytes_q   <= 3'd0;
      is_periph_q   <= 1'b0;
      tx_byte_q     <= 8'h00;
      addr_q        <= 16'h0;
      is_write_q    <= 1'b0;
      wdata_q       <= 32'h0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      gap_q         <= gap_d;
      wdog_q        <= wdog_d;
      grant_id_q    <= grant_id_d;
      flash_cs_n_q  <= flash_cs_n_d;
      ram_cs_n_q    <= ram_cs_n_d;
      periph_cs_n_q <= periph_cs_n_d;
      spi_start_q   <= spi_start_d;
      if_done_q     <= if_done_d;
      ls_done_q     <= ls_done_d;
      pe_done_q     <= pe_done_d;
      rdata_q       <= rdata_d;
      resp_err_q    <= resp_err_d;
      num_bytes_q   <= num_bytes_d;
      is_periph_q   <= is_periph_d;
      tx_byte_q     <= tx_byte_d;
      addr_q        <= addr_d;
      is_write_q    <= is_write_d;
      wdata_q       <= wdata_d;
    end
  end

  assign if_done           = if_done_q;
  assign ls_done           = ls_done_q;
  assign pe_done           = pe_done_q;
  assign rdata             = rdata_q;
  assign resp_err          = resp_err_q;
  assign grant_id          = grant_id_q;
  assign spi_start         = spi_start_q;
  assign spi_num_bytes     = num_bytes_q;
  assign spi_is_peripheral = is_periph_q;
  assign spi_tx_byte       = tx_byte_q;
  assign spi_addr          = addr_q;
  assign spi_is_write      = is_write_q;
  assign spi_wdata         = wdata_q;
  assign flash_cs_n        = flash_cs_n_q;
  assign ram_cs_n          = ram_cs_n_q;
  assign periph_cs_n       = periph_cs_n_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: stimulus queues expected grants and
// responses, monitors compare them when spi_start rises or a *_done rises.
module tb_spi_bus_arbiter;

  localparam int CS_GAP = 2;

  logic        clk, rst;
  logic        if_req, if_done;
  logic [16:0] if_addr;
  logic        ls_req, ls_is_write, ls_done;
  logic [16:0] ls_addr;
  logic [2:0]  ls_num_bytes;
  logic [31:0] ls_wdata;
  logic        pe_req, pe_done;
  logic [7:0]  pe_tx_byte;
  logic [31:0] rdata;
  logic        resp_err;
  logic [1:0]  grant_id;
  logic        spi_start, spi_done;
  logic [2:0]  spi_num_bytes;
  logic        spi_is_peripheral, spi_is_write;
  logic [7:0]  spi_tx_byte;
  logic [15:0] spi_addr;
  logic [31:0] spi_wdata, spi_rdata;
  logic        flash_cs_n, ram_cs_n, periph_cs_n;

  spi_bus_arbiter #(.ADDR_W(17), .TIMEOUT(255), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_is_write(ls_is_write),
    .ls_num_bytes(ls_num_bytes), .ls_wdata(ls_wdata), .ls_done(ls_done),
    .pe_req(pe_req), .pe_tx_byte(pe_tx_byte), .pe_done(pe_done),
    .rdata(rdata), .resp_err(resp_err), .grant_id(grant_id),
    .spi_start(spi_start), .spi_done(spi_done), .spi_num_bytes(spi_num_bytes),
    .spi_is_peripheral(spi_is_peripheral), .spi_tx_byte(spi_tx_byte),
    .spi_addr(spi_addr), .spi_is_write(spi_is_write), .spi_wdata(spi_wdata),
    .spi_rdata(spi_rdata), .flash_cs_n(flash_cs_n), .ram_cs_n(ram_cs_n),
    .periph_cs_n(periph_cs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [2:0]  cs;     // {flash_cs_n, ram_cs_n, periph_cs_n}
    logic [15:0] addr;
    logic [2:0]  nb;
    logic        wr;
    logic [31:0] wdata;
    logic [7:0]  tx;
  } grant_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  grant_t gq[$];
  resp_t  rq[$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // SPI master model: answers each spi_start after m_lat cycles unless m_hang.
  int          m_lat  = 10;
  logic [31:0] m_data = 32'h0;
  bit          m_hang = 1'b0;

  initial begin
    spi_done  = 1'b0;
    spi_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (spi_start) begin
        if (!m_hang) begin
          repeat (m_lat) @(posedge clk);
          #1 spi_done = 1'b1; spi_rdata = m_data;
          @(posedge clk);
          #1 spi_done = 1'b0;
        end
        while (spi_start) begin
          @(posedge clk); #1;
        end
      end
    end
  end

  // Monitors: grant scoreboard, response scoreboard, bus invariants, CS gap.
  int   cyc = 0, cs_low_cyc = 0;
  logic start_prev = 1'b0, prev_all_high = 1'b1;
  logic [2:0] done_prev = 3'b0;
  int   bad_inv = 0, bad_gap = 0, n_gaps = 0, gap_run = 0;
  bit   seen_tx = 1'b0;

  always @(negedge clk) begin
    logic       all_high;
    logic [2:0] done_vec;
    int         n_low;
    grant_t     g;
    resp_t      r;
    cyc++;
    all_high = flash_cs_n & ram_cs_n & periph_cs_n;
    n_low    = 3 - $countones({flash_cs_n, ram_cs_n, periph_cs_n});
    done_vec = {pe_done, ls_done, if_done};

    if (!all_high && prev_all_high) cs_low_cyc = cyc;
    if (n_low > 1) bad_inv++;
    if (spi_start && n_low != 1) bad_inv++;
    if ($countones(done_vec) > 1) bad_inv++;

    if (rst) begin
      seen_tx = 1'b0;
      gap_run = 0;
    end else if (all_high) begin
      gap_run++;
    end else begin
      if (prev_all_high && seen_tx) begin
        n_gaps++;
        if (gap_run < CS_GAP) bad_gap++;
      end
      seen_tx = 1'b1;
      gap_run = 0;
    end

    if (spi_start && !start_prev) begin
      if (gq.size() == 0) begin
        check("unexpected_start", {31'b0, spi_start}, 32'h0);
      end else begin
        g = gq.pop_front();
        check("grant_id", {30'b0, grant_id}, {30'b0, g.id});
        check("cs_pattern", {29'b0, flash_cs_n, ram_cs_n, periph_cs_n}, {29'b0, g.cs});
        check("cs_to_start", cyc - cs_low_cyc, 1);
        check("spi_is_peripheral", {31'b0, spi_is_peripheral}, {31'b0, g.id == 2'd3});
        if (g.id == 2'd3) begin
          check("spi_tx_byte", {24'b0, spi_tx_byte}, {24'b0, g.tx});
        end else begin
          check("spi_addr", {16'b0, spi_addr}, {16'b0, g.addr});
          check("spi_num_bytes", {29'b0, spi_num_bytes}, {29'b0, g.nb});
          check("spi_is_write", {31'b0, spi_is_write}, {31'b0, g.wr});
          if (g.wr) check("spi_wdata", spi_wdata, g.wdata);
        end
      end
    end

    if (done_vec != 3'b0 && done_prev == 3'b0) begin
      if (rq.size() == 0) begin
        check("unexpected_done", {29'b0, done_vec}, 32'h0);
      end else begin
        r = rq.pop_front();
        check("done_id", if_done ? 32'd1 : (ls_done ? 32'd2 : 32'd3), {30'b0, r.id});
        check("rdata", rdata, r.rdata);
        check("resp_err", {31'b0, resp_err}, {31'b0, r.err});
      end
    end

    start_prev    = spi_start;
    prev_all_high = all_high;
    done_prev     = done_vec;
  end

  function automatic logic done_of(input int which);
    case (which)
      1:       return if_done;
      2:       return ls_done;
      default: return pe_done;
    endcase
  endfunction

  task automatic wait_done(input int which, input int budget);
    int n = 0;
    while (n < budget && !done_of(which)) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", {31'b0, done_of(which)}, 32'h1);
  endtask

  task automatic run_if(input logic [16:0] a, input int budget);
    if_addr = a; if_req = 1'b1;
    wait_done(1, budget);
    @(posedge clk); #1 if_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_ls(input logic [16:0] a, input logic wr, input logic [2:0] nb,
                        input logic [31:0] wd, input int budget);
    ls_addr = a; ls_is_write = wr; ls_num_bytes = nb; ls_wdata = wd; ls_req = 1'b1;
    wait_done(2, budget);
    @(posedge clk); #1 ls_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_pe(input logic [7:0] tx, input int budget);
    pe_tx_byte = tx; pe_req = 1'b1;
    wait_done(3, budget);
    @(posedge clk); #1 pe_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [1:0] id, input logic [2:0] cs, input logic [15:0] a,
                      input logic [2:0] nb, input logic wr, input logic [31:0] wd,
                      input logic [7:0] tx);
    grant_t g;
    g.id = id; g.cs = cs; g.addr = a; g.nb = nb; g.wr = wr; g.wdata = wd; g.tx = tx;
    gq.push_back(g);
  endtask

  task automatic push_resp(input logic [1:0] id, input logic [31:0] d, input logic e);
    resp_t r;
    r.id = id; r.rdata = d; r.err = e;
    rq.push_back(r);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1 rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    if_req = 0; if_addr = '0;
    ls_req = 0; ls_addr = '0; ls_is_write = 0; ls_num_bytes = 3'd4; ls_wdata = '0;
    pe_req = 0; pe_tx_byte = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_flash_cs_n", {31'b0, flash_cs_n}, 32'h1);
    check("rst_ram_cs_n", {31'b0, ram_cs_n}, 32'h1);
    check("rst_periph_cs_n", {31'b0, periph_cs_n}, 32'h1);
    check("rst_spi_start", {31'b0, spi_start}, 32'h0);
    check("rst_done", {29'b0, pe_done, ls_done, if_done}, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_grant_id", {30'b0, grant_id}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Fetch from flash.
    m_lat = 70; m_data = 32'hDEADBEEF;
    push(2'd1, 3'b011, 16'h0040, 3'd4, 1'b0, 32'h0, 8'h00);
    push_resp(2'd1, 32'hDEADBEEF, 1'b0);
    run_if(17'h00040, 200);

    // Load/store write to RAM; rdata still follows the master.
    m_lat = 10; m_data = 32'h0BADF00D;
    push(2'd2, 3'b101, 16'h0010, 3'd2, 1'b1, 32'h0000A55A, 8'h00);
    push_resp(2'd2, 32'h0BADF00D, 1'b0);
    run_ls(17'h10010, 1'b1, 3'd2, 32'h0000A55A, 100);

    // Peripheral byte.
    m_lat = 8; m_data = 32'h000000C2;
    push(2'd3, 3'b110, 16'h0000, 3'd1, 1'b0, 32'h0, 8'h9F);
    push_resp(2'd3, 32'h000000C2, 1'b0);
    run_pe(8'h9F, 100);

    // Load read that never completes: watchdog abort, rdata keeps 0xC2.
    // num_bytes = 3 is not a legal size and maps to 4.
    m_hang = 1'b1;
    push(2'd2, 3'b011, 16'h0100, 3'd4, 1'b0, 32'h0, 8'h00);
    push_resp(2'd2, 32'h000000C2, 1'b1);
    run_ls(17'h00100, 1'b0, 3'd3, 32'h0, 400);
    m_hang = 1'b0;

    // All three requesting from reset: IF, LS, PE, IF.
    do_reset(2);
    m_lat = 4; m_data = 32'h12345678;
    push(2'd1, 3'b101, 16'h0004, 3'd4, 1'b0, 32'h0, 8'h00);
    push(2'd2, 3'b011, 16'h0008, 3'd1, 1'b0, 32'h0, 8'h00);
    push(2'd3, 3'b110, 16'h0000, 3'd1, 1'b0, 32'h0, 8'h5A);
    push(2'd1, 3'b101, 16'h0004, 3'd4, 1'b0, 32'h0, 8'h00);
    for (int i = 0; i < 4; i++) push_resp((i == 3) ? 2'd1 : 2'(i + 1), 32'h12345678, 1'b0);
    fork
      begin
        run_if(17'h10004, 100);
        run_if(17'h10004, 200);
      end
      run_ls(17'h00008, 1'b0, 3'd1, 32'h0, 100);
      run_pe(8'h5A, 150);
    join

    // Reset during WAIT; IF (pending) must be regranted ahead of PE.
    m_hang = 1'b1;
    push(2'd1, 3'b011, 16'h0200, 3'd4, 1'b0, 32'h0, 8'h00);
    if_addr = 17'h00200; if_req = 1'b1;
    n = 0;
    while (n < 50 && !spi_start) begin
      @(negedge clk);
      n++;
    end
    check("hang_start_seen", {31'b0, spi_start}, 32'h1);
    pe_tx_byte = 8'h33;
    @(posedge clk); #1 pe_req = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; m_hang = 1'b0; m_lat = 6; m_data = 32'hCAFE0001;
    push(2'd1, 3'b011, 16'h0200, 3'd4, 1'b0, 32'h0, 8'h00);
    push(2'd3, 3'b110, 16'h0000, 3'd1, 1'b0, 32'h0, 8'h33);
    push_resp(2'd1, 32'hCAFE0001, 1'b0);
    push_resp(2'd3, 32'hCAFE0001, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_cs_high", {29'b0, flash_cs_n, ram_cs_n, periph_cs_n}, 32'h7);
    check("midrst_spi_start", {31'b0, spi_start}, 32'h0);
    check("midrst_done", {29'b0, pe_done, ls_done, if_done}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    wait_done(1, 100);
    @(posedge clk); #1 if_req = 1'b0;
    wait_done(3, 100);
    @(posedge clk); #1 pe_req = 1'b0;
    repeat (5) @(posedge clk);

    @(negedge clk);
    check("bus_invariants", bad_inv, 0);
    check("cs_gap_violations", bad_gap, 0);
    check("gaps_observed", {31'b0, n_gaps >= 6}, 32'h1);
    check("scoreboard_drained", gq.size() + rq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares the single SPI master (flash, SPI RAM, SPI peripheral on one sclk/mosi/miso) between three requesters: instruction fetch (IF), load/store unit (LS) and peripheral byte port (PE).
- Round-robin grant; drives the master's start/done handshake; generates per-device active-low chip selects; latches the returned data.
- Adds a watchdog so a stuck transaction cannot hang the bus.

Parameters:
ADDR_W, 17, requester address width; addr[16] selects RAM (1) or flash (0), addr[15:0] goes to the master
TIMEOUT, 255, max cycles in WAIT before abort (8-bit counter)
CS_GAP, 2, minimum cycles all chip selects stay high between transactions (1..7)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request, level, held until if_done
if_addr  in  ADDR_W  fetch address; always a 4-byte read
if_done  out  1  fetch response valid, held while if_req high
ls_req  in  1  load/store request, level
ls_addr  in  ADDR_W  load/store address
ls_is_write  in  1  1 = write
ls_num_bytes  in  3  1, 2 or 4 (other values are treated as 4)
ls_wdata  in  32  write data
ls_done  out  1  load/store response valid
pe_req  in  1  peripheral request, level
pe_tx_byte  in  8  byte sent to peripheral
pe_done  out  1  peripheral response valid
rdata  out  32  latched read data from the last completed transaction
resp_err  out  1  last transaction timed out; valid with *_done
grant_id  out  2  0 = none, 1 = IF, 2 = LS, 3 = PE
spi_start  out  1  master start_request
spi_done  in  1  master request_done
spi_num_bytes  out  3  to master
spi_is_peripheral  out  1  to master
spi_tx_byte  out  8  to master
spi_addr  out  16  to master
spi_is_write  out  1  to master
spi_wdata  out  32  to master
spi_rdata  in  32  master fetched_value
flash_cs_n  out  1  flash chip select
ram_cs_n  out  1  RAM chip select
periph_cs_n  out  1  peripheral chip select

Behaviour:
- Reset (synchronous, active high): state IDLE; all *_cs_n = 1; spi_start, all *_done, resp_err = 0; rdata = 0; grant_id = 0; rr pointer = IF; gap counter = 0. Reset mid-transaction takes effect at that edge: CS high and spi_start low on the next cycle.
- All outputs are registered. spi_* payload outputs are registered at grant and held stable until the next grant.
- States: IDLE, SETUP, WAIT, RESP.
- IDLE:
  - gap counter > 0: decrement; no grant.
  - Otherwise, if any req is high: pick the first requester at or after the rr pointer in order IF -> LS -> PE -> IF.
  - On grant: latch the winner's payload into the spi_* registers, assert that device's CS, set grant_id, set rr pointer to the requester after the winner, go to SETUP.
  - IF payload: num_bytes = 4, is_write = 0, is_peripheral = 0.
  - PE payload: is_peripheral = 1, address and write data are don't-care.
- SETUP: one cycle of CS setup; spi_start <= 1; watchdog cleared; go to WAIT.
- WAIT:
  - Watchdog increments every cycle.
  - spi_done = 1 at an edge: rdata <= spi_rdata (also for writes), spi_start <= 0, CS deasserted, resp_err <= 0, winner's done <= 1, go to RESP.
  - Watchdog == TIMEOUT with no spi_done: same transitions, except rdata unchanged and resp_err <= 1.
- RESP:
  - Hold the winner's done while its req is high.
  - Edge where req is low: done <= 0, grant_id <= 0, gap counter <= CS_GAP-1, go to IDLE.
  - Result: CS high for at least CS_GAP cycles between transactions.
- Requester dropping req during SETUP/WAIT: the transaction still completes. In RESP, done is never asserted (exits immediately) and rdata is still updated.
- At most one *_done and at most one CS is low at any time. spi_start is only high while exactly one CS is low.
- Requests arriving during a transaction wait. Simultaneous requests are resolved by the rr pointer. No requester is starved: each waits at most 2 transactions.
- Payload inputs are sampled only at grant; changes after the grant are ignored.

Test Plan:
- Single IF request, if_addr = 0x00040, model returns spi_done after 70 cycles with 0xDEADBEEF. Expect flash_cs_n low, spi_start high 1 cycle later, spi_num_bytes = 4, spi_is_write = 0; if_done with rdata = 0xDEADBEEF and resp_err = 0.
- LS write, ls_addr = 0x10010, ls_num_bytes = 2, ls_wdata = 0x0000A55A. Expect ram_cs_n low (flash_cs_n and periph_cs_n high), spi_addr = 0x0010, spi_is_write = 1, spi_wdata = 0x0000A55A; ls_done when spi_done arrives.
- IF, LS and PE all requesting continuously from reset. Expect grant order IF, LS, PE, IF. Expect at least 2 cycles of all CS high between transactions, and never two CS low at once.
- PE request with pe_tx_byte = 0x9F, model returns 0x000000C2. Expect periph_cs_n low, spi_is_peripheral = 1, spi_tx_byte = 0x9F, pe_done with rdata = 0x000000C2.
- LS read, model never asserts spi_done. After TIMEOUT = 255 cycles in WAIT: spi_start drops, CS goes high, ls_done = 1 with resp_err = 1, rdata unchanged.
- rst asserted during WAIT. Next cycle: all CS high, spi_start = 0, no *_done. A pending request is regranted after rst falls, starting from IF.
